// File: rtl/seq_mult.sv
// Multi-cycle shift-add multiplier: one WIDTH+1-bit adder iterated WIDTH times,
// optional two's-complement mode via magnitude multiply and final negation.
module seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplr;
  logic [WIDTH-1:0]   acc;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  // -2^(WIDTH-1) negates to itself, which read as unsigned is its true magnitude
  always_comb begin
    abs_a = (signed_mode && A[WIDTH-1]) ? -A : A;
    abs_b = (signed_mode && B[WIDTH-1]) ? -B : B;
  end

  always_comb begin
    sum      = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : '0);
    prod     = {acc, mplr};
    prod_fix = neg ? -prod : prod;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= abs_a;
            mplr  <= abs_b;
            acc   <= '0;
            cnt   <= '0;
            neg   <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          // Consumed multiplier bits shift out while product bits shift in
          acc   <= sum[WIDTH:1];
          mplr  <= {sum[0], mplr[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          {hi, lo} <= prod_fix;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Directed and randomised checks for seq_mult at WIDTH=16.
module tb_seq_mult;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_done_cyc = 0;

  seq_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .A(A), .B(B), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one operation; optionally fires a second start mid-operation.
  task automatic run_op(input string tag, input logic sm, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [31:0] exp,
                        input bit interfere, input bit verbose);
    int k;
    bit busy_ok;
    bit got;
    @(negedge clk);
    start = 1'b1; signed_mode = sm; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; A = ~a; B = ~b; signed_mode = ~sm;
    if (verbose) begin
      check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
      check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    end
    busy_ok = 1'b1;
    got = 1'b0;
    k = 0;
    while (!got && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (done) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
      if (interfere && k == 3) begin
        start = 1'b1; signed_mode = 1'b0; A = 16'h1234; B = 16'h5678;
      end
      if (interfere && k == 4) start = 1'b0;
    end
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    if (got) last_done_cyc = cyc;
    if (verbose) begin
      check({tag, "_latency"}, k, W + 1);
      check({tag, "_busy_span"}, {31'd0, busy_ok}, 32'd1);
      check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    end
    check({tag, "_prod"}, {hi, lo}, exp);
  endtask

  initial begin
    int first_done;
    bit seen;
    logic sm;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int sa;
    int sb;
    int unsigned ua;
    int unsigned ub;
    logic [31:0] exp;

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hilo", {hi, lo}, 32'd0);
    @(negedge clk) rst = 1'b0;

    run_op("u_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 1'b1);
    run_op("s_m3x5", 1'b1, 16'hFFFD, 16'h0005, 32'hFFFF_FFF1, 1'b0, 1'b1);
    run_op("u_fffdx5", 1'b0, 16'hFFFD, 16'h0005, 32'h0004_FFF1, 1'b0, 1'b0);
    run_op("s_minxmin", 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 1'b0);
    run_op("s_minx1", 1'b1, 16'h8000, 16'h0001, 32'hFFFF_8000, 1'b0, 1'b0);
    run_op("s_0xm1", 1'b1, 16'h0000, 16'hFFFF, 32'h0000_0000, 1'b0, 1'b0);
    run_op("s_m1xm1", 1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_op("u_3x7", 1'b0, 16'h0003, 16'h0007, 32'h0000_0015, 1'b0, 1'b0);

    // Mid-operation start must be ignored
    run_op("ign", 1'b1, 16'h0010, 16'hFFF0, 32'hFFFF_FF00, 1'b1, 1'b1);

    // Back-to-back: second start lands on the done cycle
    run_op("b2b_1", 1'b0, 16'h00FF, 16'h0101, 32'h0000_FFFF, 1'b0, 1'b0);
    first_done = last_done_cyc;
    run_op("b2b_2", 1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 1'b0, 1'b0);
    check("b2b_spacing", last_done_cyc - first_done, W + 2);

    // Reset on edge 5 of an operation
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; A = 16'h0003; B = 16'h0007;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_hilo", {hi, lo}, 32'd0);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("mid_rst_nodone", {31'd0, seen}, 32'd0);
    check("mid_rst_hold", {hi, lo}, 32'd0);
    run_op("after_rst", 1'b1, 16'hFFFE, 16'h0003, 32'hFFFF_FFFA, 1'b0, 1'b1);

    // Random sweep against the behavioural product
    for (int i = 0; i < 1000; i++) begin
      sm = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 16 == 0) ra = 16'h8000;
      if (i % 16 == 1) rb = 16'h0000;
      if (sm) begin
        sa = $signed(ra);
        sb = $signed(rb);
        exp = 32'(sa * sb);
      end else begin
        ua = ra;
        ub = rb;
        exp = ua * ub;
      end
      run_op("rand", sm, ra, rb, exp, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
